board_switch_conditioner: RTL and testbench

- Board-input front end sitting directly upstream of the CPU board top; its outputs drive the top's 4-bit `switch` input.
- Synchronises the four raw slide/push switches to the board clock and debounces each bit independently.
- Also emits single-cycle rise/fall pulses per bit, so the CPU top sees clean, glitch-free control levels and edge events.

---
 rtl/board_pkg.sv | 25 ++
 rtl/board_debounce_chan.sv | 124 ++++++++++++
 rtl/board_switch_conditioner.sv | 45 ++++
 tb/tb_board_switch_conditioner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the board switch conditioner.
//   NUM_SW_DEFAULT   : default number of switch channels
//   debounce_state_e : per-channel debounce state (IDLE / COUNTING)
//   cnt_width()      : counter width for a given cycle count (never below 1)
// No ports (package).
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int NUM_SW_DEFAULT = 4;

    typedef enum logic {
        DB_IDLE     = 1'b0,
        DB_COUNTING = 1'b1
    } debounce_state_e;

    // Width of a counter that only has to reach cycles-1.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/board_debounce_chan.sv
// -----------------------------------------------------------------------------
// board_debounce_chan
// One switch channel: two-flop synchroniser, debounce counter, stable level
// flop and registered rise/fall pulses.
// Optional feature macro: BOARD_SW_AUTOREPEAT_EN
//   When defined, a repeat counter re-pulses rise_o every REPEAT_CYCLES cycles
//   while the stable level stays high.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   raw_i    : asynchronous, bouncing switch level
//   stable_o : debounced level
//   rise_o   : one-cycle pulse on accepted 0->1 (and auto-repeats if enabled)
//   fall_o   : one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module board_debounce_chan
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("board_debounce_chan: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    debounce_state_e state;
    logic            accept;

    // The state is fully determined by whether the synchronised input
    // disagrees with the accepted level, so it is not stored separately.
    assign state  = (sync2_q != stable_q) ? DB_COUNTING : DB_IDLE;
    // Mismatch has lasted DEBOUNCE_CYCLES samples: take the new level now.
    assign accept = (state == DB_COUNTING) && (cnt_q == CNT_LAST);

`ifdef BOARD_SW_AUTOREPEAT_EN
    localparam int            RW       = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state)
            DB_IDLE: begin
                cnt_d = '0;
            end
            DB_COUNTING: begin
                if (accept) begin
                    stable_d = sync2_q;
                    rise_d   = sync2_q;
                    fall_d   = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
`ifdef BOARD_SW_AUTOREPEAT_EN
        // Runs only while the accepted level is high; a pending fall wins
        // so rise and fall can never coincide.
        rep_d = rep_q;
        if (!stable_q || accept) begin
            rep_d = '0;
        end else if (rep_q == REP_LAST) begin
            rep_d  = '0;
            rise_d = 1'b1;
        end else begin
            rep_d = rep_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
`ifdef BOARD_SW_AUTOREPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
`ifdef BOARD_SW_AUTOREPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/board_switch_conditioner.sv
// -----------------------------------------------------------------------------
// board_switch_conditioner
// Synchronises and debounces NUM_SW raw board switches, producing clean levels
// plus one-cycle rise/fall pulses per bit. Channels are independent.
// Optional feature macro: BOARD_SW_AUTOREPEAT_EN (auto-repeat of sw_rise while
// a bit stays high, period REPEAT_CYCLES).
// Ports:
//   clkOld    : board clock, rising edge
//   reset     : synchronous active-low reset
//   sw_raw    : raw asynchronous switch levels
//   sw_stable : debounced levels
//   sw_rise   : one-cycle 0->1 pulses
//   sw_fall   : one-cycle 1->0 pulses
// All outputs are registered.
// -----------------------------------------------------------------------------
module board_switch_conditioner
    import board_pkg::*;
#(
    parameter int NUM_SW          = NUM_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic              clkOld,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_stable,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall
);

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_chan
        board_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk_i    (clkOld),
            .rst_ni   (reset),
            .raw_i    (sw_raw[gi]),
            .stable_o (sw_stable[gi]),
            .rise_o   (sw_rise[gi]),
            .fall_o   (sw_fall[gi])
        );
    end

endmodule

// File: tb/tb_board_switch_conditioner.sv
// -----------------------------------------------------------------------------
// tb_board_switch_conditioner
// Directed stimulus with a scoreboard: expected pulse events (cycle, level,
// rise, fall) and expected level snapshots are queued by the stimulus; the
// monitor compares whenever the DUT emits a pulse or a snapshot is due.
// -----------------------------------------------------------------------------
module tb_board_switch_conditioner;

    localparam int DEB = 4;
    localparam int REP = 8;
    localparam int LAT = 2 + DEB;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  st;
        logic [3:0]  ri;
        logic [3:0]  fa;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_stable, sw_rise, sw_fall;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        done = 1'b0;

    exp_t pulse_q[$];
    exp_t lvl_q[$];

    board_switch_conditioner #(
        .NUM_SW          (4),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clkOld    (clk),
        .reset     (rst_n),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_pulse(input int unsigned c, input logic [3:0] st,
                              input logic [3:0] ri, input logic [3:0] fa);
        exp_t e;
        e.cyc = c; e.st = st; e.ri = ri; e.fa = fa;
        pulse_q.push_back(e);
    endtask

    task automatic push_lvl(input int unsigned c, input logic [3:0] st,
                            input logic [3:0] ri, input logic [3:0] fa);
        exp_t e;
        e.cyc = c; e.st = st; e.ri = ri; e.fa = fa;
        lvl_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new raw value and queue the expected accepted change.
    task automatic drive(input logic [3:0] v, input logic [3:0] cur_stable);
        logic [3:0] r, f;
        sw_raw = v;
        r = v & ~cur_stable;
        f = ~v & cur_stable;
        if ((r | f) != 4'h0)
            push_pulse(cyc + LAT, v, r, f);
        $display("drive sw_raw=%h at cycle %0d", v, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if ((sw_rise | sw_fall) != 4'h0) begin
            if (pulse_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual rise=%h fall=%h stable=%h required no pulse (cycle %0d)",
                         sw_rise, sw_fall, sw_stable, cyc);
            end else begin
                exp_t e;
                e = pulse_q.pop_front();
                check("pulse_cycle",  cyc,       e.cyc);
                check("pulse_stable", sw_stable, e.st);
                check("pulse_rise",   sw_rise,   e.ri);
                check("pulse_fall",   sw_fall,   e.fa);
                $display("pulse cycle=%0d stable=%h rise=%h fall=%h", cyc, sw_stable, sw_rise, sw_fall);
            end
        end
        if (lvl_q.size() != 0 && lvl_q[0].cyc == cyc) begin
            exp_t e;
            e = lvl_q.pop_front();
            check("level_stable", sw_stable, e.st);
            check("level_rise",   sw_rise,   e.ri);
            check("level_fall",   sw_fall,   e.fa);
            $display("level cycle=%0d stable=%h rise=%h fall=%h", cyc, sw_stable, sw_rise, sw_fall);
        end
        if (done || cyc > 3000) begin
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL timeout actual cycle=%0d required done before 3000", cyc);
            end
            check("pulses_outstanding", pulse_q.size(), 0);
            check("levels_outstanding", lvl_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        int unsigned k;
        rst_n  = 1'b0;
        sw_raw = 4'hF;
        // Reset held through edges 1..3 with all switches high.
        push_lvl(3, 4'h0, 4'h0, 4'h0);
        step(3);
        rst_n = 1'b1;
        push_pulse(cyc + LAT, 4'hF, 4'hF, 4'h0);
        step(10);

        // Drop bits 3..1, leaving only bit 0 high.
        drive(4'h1, 4'hF);
        step(10);

        // Bounce on bit 1: high 2 cycles, low 2 cycles, never long enough.
        for (int i = 0; i < 5; i++) begin
            sw_raw[1] = 1'b1;
            step(2);
            sw_raw[1] = 1'b0;
            step(2);
        end
        step(10);
        push_lvl(cyc + 1, 4'h1, 4'h0, 4'h0);
        step(2);

        // Clean fall on bit 0.
        drive(4'h0, 4'h1);
        step(10);

        // Simultaneous rise on bits 3 and 1, then simultaneous fall.
        drive(4'hA, 4'h0);
        step(10);
        drive(4'h0, 4'hA);
        step(10);

        // Reset during a count on bit 2: partial count discarded.
        k = cyc;
        sw_raw = 4'h4;
        push_lvl(k + 4, 4'h0, 4'h0, 4'h0);
        step(3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        push_pulse(cyc + LAT, 4'h4, 4'h4, 4'h0);
        step(12);

        // Hold bit 3 high for 40 cycles.
        k = cyc;
        drive(4'hC, 4'h4);
`ifdef BOARD_SW_AUTOREPEAT_EN
        for (int n = 1; LAT + REP * n <= 40; n++)
            push_pulse(k + LAT + REP * n, 4'hC, 4'h8, 4'h0);
`endif
        step(40);
        done = 1'b1;
    end

endmodule
